// File: rtl/rv32i_enc_pkg.sv
// Shared constants for the RV32I instruction encoder: mnemonic codes, opcodes,
// funct fields, instruction formats and the per-mnemonic encoding lookup.
package rv32i_enc_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned MNEM_W = 5;
    localparam int unsigned REG_W  = 5;

    localparam logic [MNEM_W-1:0] MN_ADD  = 5'd0,  MN_SUB   = 5'd1,  MN_SLL   = 5'd2;
    localparam logic [MNEM_W-1:0] MN_SLT  = 5'd3,  MN_SLTU  = 5'd4,  MN_XOR   = 5'd5;
    localparam logic [MNEM_W-1:0] MN_SRL  = 5'd6,  MN_OR    = 5'd7,  MN_AND   = 5'd8;
    localparam logic [MNEM_W-1:0] MN_ADDI = 5'd9,  MN_ANDI  = 5'd10, MN_XORI  = 5'd11;
    localparam logic [MNEM_W-1:0] MN_ORI  = 5'd12, MN_SLTI  = 5'd13, MN_SLTIU = 5'd14;
    localparam logic [MNEM_W-1:0] MN_LB   = 5'd15, MN_LW    = 5'd16, MN_SB    = 5'd17;
    localparam logic [MNEM_W-1:0] MN_SW   = 5'd18, MN_BEQ   = 5'd19, MN_BNE   = 5'd20;
    localparam logic [MNEM_W-1:0] MN_BLT  = 5'd21, MN_BGE   = 5'd22, MN_JALR  = 5'd23;
    localparam logic [MNEM_W-1:0] MN_JAL  = 5'd24, MN_LUI   = 5'd25, MN_AUIPC = 5'd26;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR = 3'b100, F3_SR  = 3'b101, F3_OR  = 3'b110, F3_AND  = 3'b111;
    localparam logic [2:0] F3_B   = 3'b000, F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000, F3_BNE = 3'b001, F3_BLT = 3'b100, F3_BGE  = 3'b101;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;

    typedef struct packed {
        fmt_e       fmt;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
    } enc_info_t;

    // Format, opcode and funct fields for a mnemonic; FMT_BAD marks illegal codes.
    function automatic enc_info_t mnem_info(input logic [MNEM_W-1:0] mnem);
        enc_info_t info;
        info = '{fmt: FMT_BAD, op: 7'b0, f3: 3'b0, f7: F7_ZERO};
        case (mnem)
            MN_ADD:   info = '{FMT_R, OP_R, F3_ADD, F7_ZERO};
            MN_SUB:   info = '{FMT_R, OP_R, F3_ADD, F7_SUB};
            MN_SLL:   info = '{FMT_R, OP_R, F3_SLL, F7_ZERO};
            MN_SLT:   info = '{FMT_R, OP_R, F3_SLT, F7_ZERO};
            MN_SLTU:  info = '{FMT_R, OP_R, F3_SLTU, F7_ZERO};
            MN_XOR:   info = '{FMT_R, OP_R, F3_XOR, F7_ZERO};
            MN_SRL:   info = '{FMT_R, OP_R, F3_SR, F7_ZERO};
            MN_OR:    info = '{FMT_R, OP_R, F3_OR, F7_ZERO};
            MN_AND:   info = '{FMT_R, OP_R, F3_AND, F7_ZERO};
            MN_ADDI:  info = '{FMT_I, OP_I, F3_ADD, F7_ZERO};
            MN_ANDI:  info = '{FMT_I, OP_I, F3_AND, F7_ZERO};
            MN_XORI:  info = '{FMT_I, OP_I, F3_XOR, F7_ZERO};
            MN_ORI:   info = '{FMT_I, OP_I, F3_OR, F7_ZERO};
            MN_SLTI:  info = '{FMT_I, OP_I, F3_SLT, F7_ZERO};
            MN_SLTIU: info = '{FMT_I, OP_I, F3_SLTU, F7_ZERO};
            MN_LB:    info = '{FMT_I, OP_LOAD, F3_B, F7_ZERO};
            MN_LW:    info = '{FMT_I, OP_LOAD, F3_W, F7_ZERO};
            MN_SB:    info = '{FMT_S, OP_STORE, F3_B, F7_ZERO};
            MN_SW:    info = '{FMT_S, OP_STORE, F3_W, F7_ZERO};
            MN_BEQ:   info = '{FMT_B, OP_BRANCH, F3_BEQ, F7_ZERO};
            MN_BNE:   info = '{FMT_B, OP_BRANCH, F3_BNE, F7_ZERO};
            MN_BLT:   info = '{FMT_B, OP_BRANCH, F3_BLT, F7_ZERO};
            MN_BGE:   info = '{FMT_B, OP_BRANCH, F3_BGE, F7_ZERO};
            MN_JALR:  info = '{FMT_I, OP_JALR, 3'b000, F7_ZERO};
            MN_JAL:   info = '{FMT_J, OP_JAL, 3'b000, F7_ZERO};
            MN_LUI:   info = '{FMT_U, OP_LUI, 3'b000, F7_ZERO};
            MN_AUIPC: info = '{FMT_U, OP_AUIPC, 3'b000, F7_ZERO};
            default:  info = '{FMT_BAD, 7'b0, 3'b0, F7_ZERO};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/rv32i_imm_pack.sv
// Combinational packer: mnemonic + operands -> 32-bit RV32I word, plus legality.
// With IMM_RANGE_CHECK_EN defined, immediates that do not fit their format are rejected.
module rv32i_imm_pack
    import rv32i_enc_pkg::*;
(
    input  logic [MNEM_W-1:0] mnem_i,
    input  logic [REG_W-1:0]  rd_i,
    input  logic [REG_W-1:0]  rs1_i,
    input  logic [REG_W-1:0]  rs2_i,
    input  logic [XLEN-1:0]   imm_i,
    output logic [XLEN-1:0]   word_c,
    output logic              ok_c
);

    enc_info_t info;
    logic      range_ok;

    assign info = mnem_info(mnem_i);

    always_comb begin
        word_c = '0;
        case (info.fmt)
            FMT_R: word_c = {info.f7, rs2_i, rs1_i, info.f3, rd_i, info.op};
            FMT_I: word_c = {imm_i[11:0], rs1_i, info.f3, rd_i, info.op};
            FMT_S: word_c = {imm_i[11:5], rs2_i, rs1_i, info.f3, imm_i[4:0], info.op};
            FMT_B: word_c = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, info.f3,
                             imm_i[4:1], imm_i[11], info.op};
            FMT_U: word_c = {imm_i[31:12], rd_i, info.op};
            FMT_J: word_c = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, info.op};
            default: word_c = '0;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Signed fit means every bit above the sign position equals the sign bit.
    always_comb begin
        range_ok = 1'b1;
        case (info.fmt)
            FMT_I, FMT_S: range_ok = (imm_i[31:11] == {21{imm_i[11]}});
            FMT_B:        range_ok = (imm_i[31:12] == {20{imm_i[12]}}) && !imm_i[0];
            FMT_J:        range_ok = (imm_i[31:20] == {12{imm_i[20]}}) && !imm_i[0];
            FMT_U:        range_ok = (imm_i[11:0] == 12'h000);
            default:      range_ok = 1'b1;
        endcase
    end
`else
    assign range_ok = 1'b1;
`endif

    assign ok_c = (info.fmt != FMT_BAD) && range_ok;

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Program loader: encodes symbolic RV32I commands and writes them to consecutive IMEM words.
// Optional immediate range checking is enabled by defining IMM_RANGE_CHECK_EN.
module rv32i_instr_encoder
    import rv32i_enc_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_mnem,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_rs1,
    input  logic [4:0]        cmd_rs2,
    input  logic [31:0]       cmd_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic              busy,
    output logic [CNT_W-1:0]  count,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_READY, S_WRITE} state_e;

    state_e            state_q;
    logic              stop_q;
    logic              ready_q, we_q, busy_q, err_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       enc_word;
    logic              enc_ok;

    rv32i_imm_pack u_pack (
        .mnem_i (cmd_mnem),
        .rd_i   (cmd_rd),
        .rs1_i  (cmd_rs1),
        .rs2_i  (cmd_rs2),
        .imm_i  (cmd_imm),
        .word_c (enc_word),
        .ok_c   (enc_ok)
    );

    assign addr_d  = addr_q + ADDR_W'(4);
    assign count_d = (&count_q) ? count_q : count_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            stop_q  <= 1'b0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q  <= base_addr & ~ADDR_W'(3);
                        count_q <= '0;
                        err_q   <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_READY;
                    end
                end
                S_READY: begin
                    // stop wins over a command presented in the same cycle
                    if (stop) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (cmd_valid) begin
                        if (enc_ok) begin
                            wdata_q <= enc_word;
                            we_q    <= 1'b1;
                            ready_q <= 1'b0;
                            stop_q  <= 1'b0;
                            state_q <= S_WRITE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (imem_ack) begin
                        we_q    <= 1'b0;
                        addr_q  <= addr_d;
                        count_q <= count_d;
                        stop_q  <= 1'b0;
                        if (stop_q || stop) begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            ready_q <= 1'b1;
                            state_q <= S_READY;
                        end
                    end else if (stop) begin
                        stop_q <= 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = busy_q;
    assign count      = count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Self-checking bench for rv32i_instr_encoder: directed cases plus random commands
// checked against an arithmetic reference encoder (honours IMM_RANGE_CHECK_EN).
module tb_rv32i_instr_encoder;

    logic        clk = 1'b0;
    logic        rst, start, stop, cmd_valid, cmd_ready, imem_we, imem_ack, busy, err;
    logic [31:0] base_addr, cmd_imm, imem_addr, imem_wdata;
    logic [4:0]  cmd_mnem, cmd_rd, cmd_rs1, cmd_rs2;
    logic [15:0] count;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_addr;
    logic [15:0] m_cnt;
    logic        m_err;

    rv32i_instr_encoder dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .base_addr(base_addr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mnem(cmd_mnem),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_ack(imem_ack), .busy(busy), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference encoder built from field positions and plain integer arithmetic.
    function automatic bit ref_enc(input int m, input int rd, input int rs1, input int rs2,
                                   input logic [31:0] imm, output logic [31:0] w);
        int     op, f3, f7, s;
        byte    fmt;
        longint u, x;
        bit     ok;
        op = 0; f3 = 0; f7 = 0; fmt = "?"; x = 0;
        s = $signed(imm);
        u = imm;
        case (m)
            0: begin fmt = "R"; op = 'h33; f3 = 0; end
            1: begin fmt = "R"; op = 'h33; f3 = 0; f7 = 'h20; end
            2: begin fmt = "R"; op = 'h33; f3 = 1; end
            3: begin fmt = "R"; op = 'h33; f3 = 2; end
            4: begin fmt = "R"; op = 'h33; f3 = 3; end
            5: begin fmt = "R"; op = 'h33; f3 = 4; end
            6: begin fmt = "R"; op = 'h33; f3 = 5; end
            7: begin fmt = "R"; op = 'h33; f3 = 6; end
            8: begin fmt = "R"; op = 'h33; f3 = 7; end
            9: begin fmt = "I"; op = 'h13; f3 = 0; end
            10: begin fmt = "I"; op = 'h13; f3 = 7; end
            11: begin fmt = "I"; op = 'h13; f3 = 4; end
            12: begin fmt = "I"; op = 'h13; f3 = 6; end
            13: begin fmt = "I"; op = 'h13; f3 = 2; end
            14: begin fmt = "I"; op = 'h13; f3 = 3; end
            15: begin fmt = "I"; op = 'h03; f3 = 0; end
            16: begin fmt = "I"; op = 'h03; f3 = 2; end
            17: begin fmt = "S"; op = 'h23; f3 = 0; end
            18: begin fmt = "S"; op = 'h23; f3 = 2; end
            19: begin fmt = "B"; op = 'h63; f3 = 0; end
            20: begin fmt = "B"; op = 'h63; f3 = 1; end
            21: begin fmt = "B"; op = 'h63; f3 = 4; end
            22: begin fmt = "B"; op = 'h63; f3 = 5; end
            23: begin fmt = "I"; op = 'h67; f3 = 0; end
            24: begin fmt = "J"; op = 'h6F; end
            25: begin fmt = "U"; op = 'h37; end
            26: begin fmt = "U"; op = 'h17; end
            default: fmt = "?";
        endcase
        ok = (fmt != "?");
`ifdef IMM_RANGE_CHECK_EN
        if (fmt == "I" || fmt == "S") ok = ok && (s >= -2048) && (s <= 2047);
        if (fmt == "B") ok = ok && (s >= -4096) && (s <= 4095) && (s % 2 == 0);
        if (fmt == "J") ok = ok && (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
        if (fmt == "U") ok = ok && ((u % 4096) == 0);
`else
        if (s == 0) ok = ok && 1'b1;
`endif
        case (fmt)
            "R": x = (longint'(f7) << 25) + (longint'(rs2) << 20) + (longint'(rs1) << 15)
                     + (longint'(f3) << 12) + (longint'(rd) << 7) + op;
            "I": x = ((u % 4096) << 20) + (longint'(rs1) << 15) + (longint'(f3) << 12)
                     + (longint'(rd) << 7) + op;
            "S": x = (((u >> 5) % 128) << 25) + (longint'(rs2) << 20) + (longint'(rs1) << 15)
                     + (longint'(f3) << 12) + ((u % 32) << 7) + op;
            "B": x = (((u >> 12) % 2) << 31) + (((u >> 5) % 64) << 25) + (longint'(rs2) << 20)
                     + (longint'(rs1) << 15) + (longint'(f3) << 12) + (((u >> 1) % 16) << 8)
                     + (((u >> 11) % 2) << 7) + op;
            "U": x = (u - (u % 4096)) + (longint'(rd) << 7) + op;
            "J": x = (((u >> 20) % 2) << 31) + (((u >> 1) % 1024) << 21)
                     + (((u >> 11) % 2) << 20) + (((u >> 12) % 256) << 12)
                     + (longint'(rd) << 7) + op;
            default: x = 0;
        endcase
        w = 32'(x);
        return ok;
    endfunction

    task automatic do_start(input logic [31:0] base);
        @(negedge clk);
        start = 1'b1; base_addr = base;
        @(negedge clk);
        start = 1'b0;
        m_addr = base & 32'hFFFF_FFFC; m_cnt = '0; m_err = 1'b0;
        check("start_busy", {31'b0, busy}, 32'd1);
        check("start_rdy", {31'b0, cmd_ready}, 32'd1);
        check("start_err", {31'b0, err}, 32'd0);
        check("start_cnt", {16'b0, count}, 32'd0);
    endtask

    task automatic do_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_busy", {31'b0, busy}, 32'd0);
        check("stop_rdy", {31'b0, cmd_ready}, 32'd0);
    endtask

    // One command: present, check the write, hold ack low 'hold' cycles, then ack.
    task automatic send(input int m, input int rd, input int rs1, input int rs2,
                        input logic [31:0] imm, input int hold, input bit stop_mid,
                        input bit use_lit, input logic [31:0] lit);
        logic [31:0] w;
        bit          ok;
        ok = ref_enc(m, rd, rs1, rs2, imm, w);
        @(negedge clk);
        check("pre_rdy", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_mnem = 5'(m); cmd_rd = 5'(rd); cmd_rs1 = 5'(rs1); cmd_rs2 = 5'(rs2); cmd_imm = imm;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (!ok) begin
            m_err = 1'b1;
            check("rej_err", {31'b0, err}, 32'd1);
            check("rej_we", {31'b0, imem_we}, 32'd0);
            check("rej_rdy", {31'b0, cmd_ready}, 32'd1);
            check("rej_cnt", {16'b0, count}, {16'b0, m_cnt});
        end else begin
            check("wr_we", {31'b0, imem_we}, 32'd1);
            check("wr_addr", imem_addr, m_addr);
            check("wr_data", imem_wdata, w);
            if (use_lit) check("wr_lit", imem_wdata, lit);
            check("wr_rdy", {31'b0, cmd_ready}, 32'd0);
            for (int k = 0; k < hold; k++) begin
                stop = stop_mid && (k == 0);
                @(negedge clk);
                stop = 1'b0;
                check("hold_we", {31'b0, imem_we}, 32'd1);
                check("hold_addr", imem_addr, m_addr);
                check("hold_data", imem_wdata, w);
                check("hold_rdy", {31'b0, cmd_ready}, 32'd0);
            end
            imem_ack = 1'b1;
            @(negedge clk);
            imem_ack = 1'b0;
            m_addr = m_addr + 32'd4;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            check("ack_we", {31'b0, imem_we}, 32'd0);
            check("ack_cnt", {16'b0, count}, {16'b0, m_cnt});
            check("ack_busy", {31'b0, busy}, {31'b0, !stop_mid});
            check("ack_rdy", {31'b0, cmd_ready}, {31'b0, !stop_mid});
            check("ack_err", {31'b0, err}, {31'b0, m_err});
        end
    endtask

    initial begin
        logic [31:0] rimm;
        rst = 1'b1; start = 1'b0; stop = 1'b0; base_addr = '0; cmd_valid = 1'b0;
        cmd_mnem = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0; imem_ack = 1'b0;
        m_addr = '0; m_cnt = '0; m_err = 1'b0;
        @(negedge clk);
        check("rst_rdy", {31'b0, cmd_ready}, 32'd0);
        check("rst_we", {31'b0, imem_we}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_data", imem_wdata, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_cnt", {16'b0, count}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        rst = 1'b0;

        // Directed encodings
        do_start(32'h100);
        send(9, 1, 0, 0, 32'd5, 0, 0, 1, 32'h00500093);
        do_stop();
        do_start(32'h100);
        send(0, 3, 1, 2, 32'd0, 0, 0, 1, 32'h002081B3);
        send(1, 3, 1, 2, 32'd0, 1, 0, 1, 32'h402081B3);
        send(18, 0, 1, 2, 32'd8, 0, 0, 1, 32'h0020A423);
        send(19, 0, 1, 2, 32'd8, 0, 0, 1, 32'h00208463);
        send(24, 1, 0, 0, 32'd16, 0, 0, 1, 32'h010000EF);
        send(25, 5, 0, 0, 32'h12345000, 0, 0, 1, 32'h123452B7);

        // Ack held low 5 cycles with stop mid-write: back to IDLE after ack
        send(7, 4, 5, 6, 32'd0, 5, 1, 0, 32'd0);

        // Command in IDLE is not accepted
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mnem = 5'd0;
        repeat (2) @(negedge clk);
        cmd_valid = 1'b0;
        check("idle_we", {31'b0, imem_we}, 32'd0);
        check("idle_rdy", {31'b0, cmd_ready}, 32'd0);

        // Illegal mnemonic, start while busy, range-checked immediate
        do_start(32'h200);
        send(30, 1, 2, 3, 32'd0, 0, 0, 0, 32'd0);
        @(negedge clk);
        start = 1'b1; base_addr = 32'h800;
        @(negedge clk);
        start = 1'b0;
        send(9, 1, 1, 0, 32'd7, 0, 0, 0, 32'd0);
        send(9, 1, 0, 0, 32'd4096, 0, 0, 0, 32'd0);

        // stop and command in the same cycle: stop wins, nothing written
        @(negedge clk);
        stop = 1'b1; cmd_valid = 1'b1; cmd_mnem = 5'd0;
        @(negedge clk);
        stop = 1'b0; cmd_valid = 1'b0;
        check("sc_busy", {31'b0, busy}, 32'd0);
        check("sc_we", {31'b0, imem_we}, 32'd0);

        // Address wrap at top of space; start clears err
        do_start(32'hFFFF_FFFE);
        send(0, 1, 2, 3, 32'd0, 0, 0, 0, 32'd0);
        send(0, 4, 5, 6, 32'd0, 0, 0, 0, 32'd0);

        // Random commands
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0: rimm = $urandom;
                1: rimm = 32'(int'($urandom_range(0, 8191)) - 4096);
                2: rimm = $urandom & 32'hFFFF_F000;
                default: rimm = 32'($urandom_range(0, 255) * 2);
            endcase
            send(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 rimm, int'($urandom_range(0, 3)), 0, 0, 32'd0);
        end

        // Reset asserted mid-write drops everything asynchronously
        do_stop();
        do_start(32'h40);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mnem = 5'd0; cmd_rd = 5'd1; cmd_rs1 = 5'd2; cmd_rs2 = 5'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rw_we", {31'b0, imem_we}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rw_we0", {31'b0, imem_we}, 32'd0);
        check("rw_addr", imem_addr, 32'd0);
        check("rw_data", imem_wdata, 32'd0);
        check("rw_busy", {31'b0, busy}, 32'd0);
        check("rw_rdy", {31'b0, cmd_ready}, 32'd0);
        check("rw_cnt", {16'b0, count}, 32'd0);
        check("rw_err", {31'b0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_busy", {31'b0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
